// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: staging/handshake bundle between the register slave and the scan driver.
// master = register side (drives enable, write strobe and values), slave = scan driver.
interface seven_seg_scan_if;
    logic        disp_en;
    logic        disp_wr;
    logic [31:0] disp_data;
    logic [7:0]  disp_dp;
    logic [7:0]  disp_blank;
    logic        disp_busy;
    logic        frame_done;

    modport master (
        output disp_en, disp_wr, disp_data, disp_dp, disp_blank,
        input  disp_busy, frame_done
    );

    modport slave (
        input  disp_en, disp_wr, disp_data, disp_dp, disp_blank,
        output disp_busy, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed seven-segment scan driver.
// Values written through the bus are staged and committed to the displayed
// (active) copy only at a frame boundary, so a frame never mixes two values.
// Build option: define SEVSEG_LZB_EN to blank leading zeros of the active value.
//
// state | meaning
// IDLE  | display dark, prescaler/index held at 0, pending stage commits immediately
// SCAN  | prescaler runs, one digit lit per CLK_DIV cycles
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    seven_seg_scan_if.slave       bus,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_LOW  = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = {7{SEG_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_LOW}};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic              scan_now;
    logic              tick;
    logic              boundary;
    logic [CNT_W-1:0]  count_q;
    logic [IDX_W-1:0]  idx_q;
    logic [2:0]        idx8;
    logic              pending_q;
    logic              frame_done_q;
    logic [31:0]       stage_data_q, active_data_q;
    logic [7:0]        stage_dp_q, active_dp_q;
    logic [7:0]        stage_blank_q, active_blank_q;
    logic [7:0]        lzb_mask;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic [NUM_DIGITS-1:0] cur_sel;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    // Next state; scanning only counts while enable is still high in SCAN,
    // so dropping enable behaves as IDLE on that same edge.
    always_comb begin
        state_d  = state_q;
        scan_now = 1'b0;
        case (state_q)
            IDLE:    if (bus.disp_en) state_d = SCAN;
            SCAN:    if (bus.disp_en) scan_now = 1'b1;
                     else             state_d  = IDLE;
            default: state_d = IDLE;
        endcase
        tick     = scan_now && (count_q == CNT_LAST);
        boundary = scan_now ? (tick && (idx_q == IDX_LAST)) : pending_q;
    end

    // Prescaler and digit index
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            count_q <= '0;
            idx_q   <= '0;
        end else if (scan_now) begin
            if (tick) begin
                count_q <= '0;
                idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end else begin
            count_q <= '0;
            idx_q   <= '0;
        end
    end

    // Staging/active double buffer; the commit reads the old staging copy,
    // so a write landing on the boundary edge stays pending for the next frame.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            stage_data_q   <= '0;
            stage_dp_q     <= '0;
            stage_blank_q  <= '0;
            active_data_q  <= '0;
            active_dp_q    <= '0;
            active_blank_q <= '0;
            pending_q      <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            frame_done_q <= boundary;
            if (boundary && pending_q) begin
                active_data_q  <= stage_data_q;
                active_dp_q    <= stage_dp_q;
                active_blank_q <= stage_blank_q;
            end
            if (bus.disp_wr) begin
                stage_data_q  <= bus.disp_data;
                stage_dp_q    <= bus.disp_dp;
                stage_blank_q <= bus.disp_blank;
                pending_q     <= 1'b1;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end
        end
    end

`ifdef SEVSEG_LZB_EN
    // Digits above the most significant non-zero nibble are dark; digit 0 never is.
    always_comb begin
        logic seen;
        lzb_mask = '0;
        seen     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (active_data_q[4*i +: 4] != 4'h0) seen = 1'b1;
            if (!seen) lzb_mask[i] = 1'b1;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Current digit's nibble, blanking and select pattern
    always_comb begin
        idx8      = 3'(idx_q);
        cur_nib   = active_data_q[{idx8, 2'b00} +: 4];
        cur_blank = active_blank_q[idx8] | lzb_mask[idx8];
        cur_sel   = NUM_DIGITS'(1) << idx_q;
    end

    // Registered pin stage; everything dark outside scanning or in a blanked slot
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= SEG_LOW;
        end else if (scan_now && !cur_blank) begin
            an  <= cur_sel ^ AN_OFF;
            seg <= hex7(cur_nib) ^ SEG_OFF;
            dp  <= active_dp_q[idx8] ^ SEG_LOW;
        end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= SEG_LOW;
        end
    end

    assign bus.disp_busy  = pending_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, 4-cycle slots, active-low pins).
// Honors SEVSEG_LZB_EN in its model and directed expectations.
module tb_seven_seg_scan_driver;
    localparam int N   = 4;
    localparam int DIV = 4;
`ifdef SEVSEG_LZB_EN
    localparam int T5_LIT = 4;
    localparam logic [3:0] T6_MASK = 4'b0011;
`else
    localparam int T5_LIT = 16;
    localparam logic [3:0] T6_MASK = 4'b1111;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_if bus();
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    seven_seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .bus(bus), .seg(seg), .dp(dp), .an(an)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          m_t;
    bit          m_en_prev, m_pend, m_scan, m_bnd;
    int          m_d;
    logic [15:0] st_data, ac_data;
    logic [3:0]  st_dp, st_bl, ac_dp, ac_bl;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;

    function automatic bit dark(input int d);
        bit b;
        b = ac_bl[d];
`ifdef SEVSEG_LZB_EN
        if (d > 0 && ((ac_data >> (4*d)) == 16'h0)) b = 1'b1;
`endif
        return b;
    endfunction

    // Model: elapsed scan cycles t pick digit (t/DIV)%N; frame ends every DIV*N cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_en_prev = 0; m_pend = 0;
            st_data = '0; st_dp = '0; st_bl = '0;
            ac_data = '0; ac_dp = '0; ac_bl = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            m_scan = m_en_prev && bus.disp_en;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            if (m_scan) begin
                m_d = (m_t / DIV) % N;
                if (!dark(m_d)) begin
                    exp_an  = ~(4'b0001 << m_d);
                    exp_seg = ~hex_tbl[(ac_data >> (4*m_d)) & 16'hF];
                    exp_dp  = ~ac_dp[m_d];
                end
                m_bnd = ((m_t + 1) % (DIV*N)) == 0;
                m_t++;
            end else begin
                m_t   = 0;
                m_bnd = m_pend;
            end
            exp_fd = m_bnd;
            if (m_bnd && m_pend) begin
                ac_data = st_data; ac_dp = st_dp; ac_bl = st_bl;
            end
            if (bus.disp_wr) begin
                st_data = bus.disp_data[15:0]; st_dp = bus.disp_dp[3:0]; st_bl = bus.disp_blank[3:0];
                m_pend = 1'b1;
            end else if (m_bnd) begin
                m_pend = 1'b0;
            end
            m_en_prev = bus.disp_en;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_an", an, exp_an);
            chk("cyc_seg", seg, exp_seg);
            chk("cyc_dp", dp, exp_dp);
            chk("cyc_busy", bus.disp_busy, m_pend);
            chk("cyc_frame_done", bus.frame_done, exp_fd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
        @(negedge clk);
        bus.disp_data = d; bus.disp_dp = p; bus.disp_blank = b; bus.disp_wr = 1'b1;
        @(negedge clk);
        bus.disp_wr = 1'b0;
    endtask

    task automatic wait_fd(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.frame_done !== 1'b1 && k < 100);
        chk({nm, "_fd_seen"}, bus.frame_done, 1);
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        int k = 0;
        while (an !== v && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_an"}, an, v);
    endtask

    task automatic check_frame(input logic [3:0] mask, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input string nm);
        logic [6:0] s [4];
        logic [3:0] a;
        int n;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            if (mask[d]) begin
                a = ~(4'b0001 << d);
                wait_an(a, $sformatf("%s_d%0d", nm, d));
                chk($sformatf("%s_d%0d_seg", nm, d), seg, s[d]);
                n = 0;
                while (an === a && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                chk($sformatf("%s_d%0d_len", nm, d), n, 4);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_an2, cnt_badseg, cnt_dark, lit;
        bus.disp_en = 0; bus.disp_wr = 0; bus.disp_data = '0; bus.disp_dp = '0; bus.disp_blank = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_busy", bus.disp_busy, 0);
        chk("rst_fd", bus.frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Test 2: 0x1234
        @(negedge clk);
        bus.disp_en = 1'b1;
        wr(32'h1234, 8'h00, 8'h00);
        chk("t2_busy_set", bus.disp_busy, 1);
        wait_fd("t2");
        chk("t2_busy_clear", bus.disp_busy, 0);
        @(negedge clk);
        chk("t2_fd_one_cycle", bus.frame_done, 0);
        check_frame(4'hF, 7'h19, 7'h30, 7'h24, 7'h79, "t2");

        // Test 1: reset mid-scan at digit 2 with a pending write
        wait_an(4'b1011, "t1_at_idx2");
        bus.disp_data = 32'h5678; bus.disp_wr = 1'b1;
        @(negedge clk);
        bus.disp_wr = 1'b0;
        chk("t1_busy_pre", bus.disp_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_an", an, 4'hF);
        chk("t1_seg", seg, 7'h7F);
        chk("t1_dp", dp, 1'b1);
        chk("t1_busy", bus.disp_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_an(4'b1110, "t1_restart");
        chk("t1_restart_seg", seg, 7'h40);

        // Test 3: last write wins, single commit
        wait_fd("t3_sync");
        wr(32'hAAAA, 8'h00, 8'h00);
        wr(32'hBEEF, 8'h02, 8'h00);
        chk("t3_busy_set", bus.disp_busy, 1);
        wait_fd("t3");
        chk("t3_busy_clear", bus.disp_busy, 0);
        check_frame(4'hF, 7'h0E, 7'h06, 7'h06, 7'h03, "t3");

        // Test 4: digit 2 blanked over three frames
        wait_fd("t4_sync");
        wr(32'h8888, 8'h00, 8'h04);
        wait_fd("t4");
        cnt_an2 = 0; cnt_badseg = 0; cnt_dark = 0;
        for (int i = 0; i < 3*DIV*N; i++) begin
            @(negedge clk);
            if (an[2] === 1'b0) cnt_an2++;
            if (an === 4'hF) cnt_dark++;
            else if (seg !== 7'h00) cnt_badseg++;
        end
        chk("t4_an2_low_cycles", cnt_an2, 0);
        chk("t4_bad_seg_cycles", cnt_badseg, 0);
        chk("t4_dark_cycles", cnt_dark, 12);

        // Test 5: 0x0005, leading-zero behaviour depends on build
        wait_fd("t5_sync");
        wr(32'h0005, 8'h00, 8'h00);
        wait_fd("t5");
        lit = 0;
        for (int i = 0; i < DIV*N; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("t5_d0_an", an, 4'b1110);
                chk("t5_d0_seg", seg, 7'h12);
            end
            if (an !== 4'hF) lit++;
        end
        chk("t5_lit_cycles", lit, T5_LIT);
`ifndef SEVSEG_LZB_EN
        check_frame(4'hF, 7'h12, 7'h40, 7'h40, 7'h40, "t5");
`endif

        // Test 6: disable with a pending write
        wait_fd("t6_sync");
        wr(32'h00FF, 8'h00, 8'h00);
        bus.disp_en = 1'b0;
        @(negedge clk);
        chk("t6_an_off", an, 4'hF);
        chk("t6_fd", bus.frame_done, 1);
        chk("t6_busy", bus.disp_busy, 0);
        @(negedge clk);
        chk("t6_fd_one_cycle", bus.frame_done, 0);
        repeat (3) @(negedge clk);
        bus.disp_en = 1'b1;
        check_frame(T6_MASK, 7'h0E, 7'h0E, 7'h40, 7'h40, "t6");

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
